// File: rtl/data_sram_axi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// data_sram_axi_bridge_pkg
// Shared definitions for the data-side SRAM-like to AXI3 bridge:
//   - state_t       : bridge FSM state encoding
//   - BURST_INCR    : AXI burst type used for every transaction
//   - LEN_SINGLE    : AXI length field for a single-beat transaction
//   - size_to_axsize: maps the core's 2-bit access size to AXI ar/awsize
// ----------------------------------------------------------------------------
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Core sizes 0/1/2 (byte/half/word) are already log2(bytes).
    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// ----------------------------------------------------------------------------
// data_sram_axi_bridge
// Responder for the MEM-stage data SRAM-like interface. Each accepted request
// (addr_ok) becomes one single-beat AXI3 transaction and produces exactly one
// data_ok pulse. At most one transaction is outstanding.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   data_sram_*            SRAM-like request (req/wr/size/wstrb/addr/wdata)
//                          and response (addr_ok/data_ok/rdata)
//   ar*/r*                 AXI3 read address / read data channels
//   aw*/w*/b*              AXI3 write address / write data / write response
//   rid/rresp/rlast/bid/bresp are accepted but ignored.
//
// Optional build macro:
//   DATA_BRIDGE_POSTED_WR_EN  writes complete (data_ok) once AW and W have
//                             handshaken; the B response is collected in the
//                             background and blocks new requests until it
//                             arrives, so ordering is preserved.
// ----------------------------------------------------------------------------
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int             ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            resetn,
    // SRAM-like slave side
    input  logic            data_sram_req,
    input  logic            data_sram_wr,
    input  logic [1:0]      data_sram_size,
    input  logic [3:0]      data_sram_wstrb,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic            data_sram_addr_ok,
    output logic            data_sram_data_ok,
    output logic [31:0]     data_sram_rdata,
    // AXI read address
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [2:0]      arsize,
    output logic [7:0]      arlen,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    // AXI read data
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AXI write address
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [2:0]      awsize,
    output logic [7:0]      awlen,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    // AXI write data
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI write response
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        arvalid_reg;
    logic        rready_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic        bready_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic        data_ok_reg;
    logic        b_block;

`ifdef DATA_BRIDGE_POSTED_WR_EN
    logic        pending_b_reg;
    assign b_block = pending_b_reg;
`else
    assign b_block = 1'b0;
`endif

    // Response id/status fields carry nothing the core can act on.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, rid, rresp, rlast, bid, bresp};

    logic accept;
    assign accept = resetn && (state_reg == S_IDLE) && data_sram_req && !b_block;

    // AW and W complete independently; "all" includes a handshake this cycle.
    logic aw_fire, w_fire, aw_all, w_all;
    assign aw_fire = awvalid_reg && awready;
    assign w_fire  = wvalid_reg && wready;
    assign aw_all  = aw_done_reg || aw_fire;
    assign w_all   = w_done_reg || w_fire;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            size_reg    <= '0;
            wstrb_reg   <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            data_ok_reg <= 1'b0;
`ifdef DATA_BRIDGE_POSTED_WR_EN
            pending_b_reg <= 1'b0;
`endif
        end else begin
            data_ok_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        addr_reg  <= data_sram_addr;
                        size_reg  <= data_sram_size;
                        wstrb_reg <= data_sram_wstrb;
                        wdata_reg <= data_sram_wdata;
                        if (data_sram_wr) begin
                            state_reg   <= S_AW_W;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                        end else begin
                            state_reg   <= S_AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready_reg  <= 1'b0;
                        rdata_reg   <= rdata;
                        data_ok_reg <= 1'b1;
                        state_reg   <= S_RESP;
                    end
                end
                S_AW_W: begin
                    if (aw_fire) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (aw_all && w_all) begin
`ifdef DATA_BRIDGE_POSTED_WR_EN
                        state_reg     <= S_RESP;
                        data_ok_reg   <= 1'b1;
                        pending_b_reg <= 1'b1;
                        bready_reg    <= 1'b1;
`else
                        state_reg  <= S_B;
                        bready_reg <= 1'b1;
`endif
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_reg  <= 1'b0;
                        data_ok_reg <= 1'b1;
                        state_reg   <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
`ifdef DATA_BRIDGE_POSTED_WR_EN
            // Background B collection; never overlaps the cycle that sets it.
            if (pending_b_reg && bvalid) begin
                pending_b_reg <= 1'b0;
                bready_reg    <= 1'b0;
            end
`endif
        end
    end

    assign data_sram_addr_ok = accept;
    assign data_sram_data_ok = data_ok_reg;
    assign data_sram_rdata   = rdata_reg;

    assign arid    = AXI_ID;
    assign araddr  = addr_reg;
    assign arsize  = size_to_axsize(size_reg);
    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arvalid = arvalid_reg;
    assign rready  = rready_reg;

    assign awid    = AXI_ID;
    assign awaddr  = addr_reg;
    assign awsize  = size_to_axsize(size_reg);
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awvalid = awvalid_reg;

    assign wid     = AXI_ID;
    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_reg;

    assign bready  = bready_reg;

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
Responder for the data-side SRAM-like interface consumed by the MEM stage (req/addr_ok issued from EXE, data_ok/rdata returned to MEM). Converts each accepted request into a single-beat AXI3 master transaction and returns exactly one data_ok pulse per accepted request. At most one transaction is outstanding. Sits between the CPU core and the top-level AXI interconnect.

Parameters:
AXI_ID, 4'd1, value driven on arid/awid/wid; rid/bid not checked
ID_W, 4, width of AXI id fields

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  0=byte, 1=half, 2=word
data_sram_wstrb  in  4  byte enables (writes)
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted this cycle
data_sram_data_ok  out  1  one-cycle completion pulse (read data or write ack)
data_sram_rdata  out  32  read data, valid with data_ok
arid/araddr/arsize/arlen/arburst  out  ID_W/32/3/8/2  read address; arlen=0, arburst=2'b01, arsize={1'b0,size}
arvalid  out  1 ; arready  in  1
rid/rdata/rresp/rlast  in  ID_W/32/2/1  read data (rid/rresp/rlast ignored)
rvalid  in  1 ; rready  out  1
awid/awaddr/awsize/awlen/awburst  out  ID_W/32/3/8/2  write address; same constants as AR
awvalid  out  1 ; awready  in  1
wid/wdata/wstrb/wlast  out  ID_W/32/4/1  write data; wlast=1
wvalid  out  1 ; wready  in  1
bid/bresp  in  ID_W/2  (ignored)
bvalid  in  1 ; bready  out  1
(arlock/arcache/arprot and AW equivalents tied to 0 at top level.)

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE; all valid/ready outputs, addr_ok, data_ok =0; rdata=0; captured request regs=0. Reset mid-transaction abandons it silently; no data_ok.
- States: IDLE, AR, R, AW_W, B, RESP.
- IDLE: addr_ok = data_sram_req (combinational). On req: capture addr/size/wstrb/wdata/wr; wr=0 -> AR, wr=1 -> AW_W.
- AR: arvalid=1, araddr/arsize from captured regs, held stable until arready. arvalid&arready -> R.
- R: rready=1. rvalid -> latch rdata into data_sram_rdata, -> RESP.
- AW_W: awvalid and wvalid raised together; each deasserts independently after its own handshake (aw_done/w_done flags); both may complete same cycle or either first. Both done -> B.
- B: bready=1. bvalid -> RESP.
- RESP: data_ok=1 for exactly one cycle, rdata held; -> IDLE. addr_ok=0 in RESP, so new request accepted no earlier than cycle after data_ok.
- Minimum read latency (zero-wait slave): addr_ok at cycle 0, arvalid cycle 1, rvalid cycle 2, data_ok cycle 3.
- wstrb passed unchanged; bridge does no lane shifting (core pre-aligns wdata).
- AXI rule: no valid dropped before its ready; AR/AW/W payloads constant while valid high.
- data_ok never asserted without a prior addr_ok; count(data_ok)==count(addr_ok) at quiescence.

Optional Feature:
DATA_BRIDGE_POSTED_WR_EN: when defined, writes are posted: AW_W both-done goes to RESP immediately (data_ok without waiting for B); a pending_b flag sets and bready=1 until bvalid clears it. While pending_b=1, addr_ok is held 0 for reads and writes (ordering preserved). Undefined: write data_ok only after bvalid (behaviour above).

Decomposition:
Shared package: state encoding enum, AXI constants (BURST_INCR=2'b01, LEN_SINGLE=8'd0), size-to-arsize mapping function. No sub-module; the AW/W dual-handshake tracker is small enough to stay inline.

Test Plan:
- Word read 0x1C000000, zero-wait slave returns 0xDEADBEEF -> addr_ok c0, arvalid c1 araddr=0x1C000000 arsize=2, data_ok c3 rdata=0xDEADBEEF.
- Byte write addr 0x1003, wstrb=4'b1000, wdata=0xAB000000; awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held until wready; data_ok exactly 1 cycle after bvalid; wstrb=4'b1000, awsize=0.
- arready held low 5 cycles -> arvalid/araddr stable all 5 cycles; req held high meanwhile -> addr_ok stays 0.
- Back-to-back read, write, read with req always high -> three addr_ok, three data_ok in order, none overlapping.
- resetn low while in R -> next cycle all outputs 0, state IDLE, late rvalid produces no data_ok.
- With DATA_BRIDGE_POSTED_WR_EN: write, bvalid delayed 4 cycles -> data_ok before bvalid; following read sees addr_ok=0 until cycle after bvalid.
